i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address the block answers to.
REQ-002 The block SHALL have parameter CLK_PER_SCL_MIN, default 8, the minimum clk cycles per SCL period for which timing is guaranteed.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 scl  input  1  I2C clock from the master; no clock stretching.
REQ-006 sda  inout  1  I2C data, open-drain: driven 0 or released to Z, never driven 1.
REQ-007 ack_en  input  1  when high, ACK received write bytes; when low, NACK them.
REQ-008 tx_data  input  8  next byte to return on a read.
REQ-009 tx_next  output  1  one-cycle pulse when tx_data is latched; the host then presents the following byte.
REQ-010 rx_data  output  8  last byte written by the master.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 rw  output  1  R/W bit of the current transaction (1 = read).
REQ-013 busy  output  1  high from an address match until STOP or the return to IDLE.
REQ-014 state  output  4  current FSM state encoding, for debug.

Function
REQ-015 scl and sda SHALL pass through a 2-flop synchronizer (reset value 1); edges SHALL be detected on the synchronized values, giving 3 clk of latency.
REQ-016 START (sda fall while scl high) SHALL move the FSM from any state to ADDR, load bit counter 7, and clear the shift register; a repeated START SHALL do the same.
REQ-017 STOP (sda rise while scl high) SHALL move the FSM from any state to IDLE and release sda.
REQ-018 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-019 ADDR, WRITE: sda SHALL be shifted in MSB-first on each scl rising edge; the 3-bit counter SHALL decrement, and a wrap from 0 SHALL mark byte complete.
REQ-020 ADDR completion: if bits[7:1]==SLAVE_ADDR, then on the next scl falling edge the block SHALL drive sda low, latch rw=bit0, and enter ADDR_ACK; otherwise it SHALL enter IGNORE with sda released.
REQ-021 ADDR_ACK: on the falling edge ending the ACK clock, rw=0 SHALL release sda and enter WRITE; rw=1 SHALL latch tx_data, pulse tx_next, drive bit7, and enter READ.
REQ-022 WRITE completion: rx_data SHALL update and rx_valid SHALL pulse in the cycle the 8th rising edge is detected; on the next falling edge the block SHALL drive ACK if ack_en is high, else release sda and enter IGNORE after the ACK clock.
REQ-023 WRITE_ACK: on the following falling edge sda SHALL be released and the FSM SHALL return to WRITE with counter 7.
REQ-024 READ: on each scl falling edge the block SHALL present the next bit (0 = drive low, 1 = release); after the 8th bit's falling edge it SHALL release sda and enter READ_ACK.
REQ-025 READ_ACK: the master ACK/NACK SHALL be sampled on the rising edge; ACK SHALL latch tx_data, pulse tx_next, and drive bit7 at the next falling edge; NACK SHALL enter IGNORE.
REQ-026 IGNORE: sda SHALL stay released until START or STOP.
REQ-027 If START/STOP coincide with a data edge in the same clk, START/STOP SHALL take priority.
REQ-028 In IDLE, sda SHALL be released, busy SHALL be 0, and tx_next and rx_valid SHALL be 0.

Reset
REQ-029 While reset=0: FSM=IDLE, sda released, rx_data=0, rx_valid=0, tx_next=0, rw=0, busy=0, counter=7, synchronizers=1.
REQ-030 Reset asserted mid-transaction SHALL release sda on the next clk edge; after deassertion the block SHALL wait for a fresh START.

Structure
REQ-031 Package i2c_pkg SHALL hold the state encoding, the ACK/NACK constants and the address width.
REQ-032 The sub-module i2c_sync_edge (2-flop sync plus rise/fall detect) SHALL be instantiated once each for scl and sda.

Verification
REQ-033 Write 0xA0, 0x3C with ack_en=1: ACK on address and data, rx_data=0x3C, one rx_valid pulse, rw=0.
REQ-034 Read 0xA1, tx_data=0x96, master ACK then NACK: bus carries 0x96 then the next tx_data, two tx_next pulses, then IGNORE.
REQ-035 Address 0x42 (mismatch): sda never driven low, busy stays 0, FSM in IGNORE until STOP.
REQ-036 Write 0xA0, 0x11, then repeated START and read 0xA1: rw goes 0->1, data returns correctly, no STOP needed between.
REQ-037 Write with ack_en=0: address is ACKed, data NACKed, and rx_valid still pulses with rx_data=data.
REQ-038 Reset pulsed during the READ bit-3 low phase: sda is released within 1 clk and the FSM is in IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings and constants for the I2C target
package i2c_pkg;

    localparam int ADDR_W  = 7;
    localparam int STATE_W = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WRITE     = 4'd3,
        ST_WRITE_ACK = 4'd4,
        ST_READ      = 4'd5,
        ST_READ_ACK  = 4'd6,
        ST_IGNORE    = 4'd7
    } i2c_state_t;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [ADDR_W-1:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - host-side byte interface of the I2C target
interface i2c_slave_if;
    import i2c_pkg::*;

    logic               ack_en;
    logic [7:0]         tx_data;
    logic               tx_next;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rw;
    logic               busy;
    logic [STATE_W-1:0] state;

    modport slave (
        input  ack_en, tx_data,
        output tx_next, rx_data, rx_valid, rw, busy, state
    );

    modport master (
        output ack_en, tx_data,
        input  tx_next, rx_data, rx_valid, rw, busy, state
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchronizer with rise/fall detect
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // sr[1:0] is the synchronizer proper; sr[2] is the previous synced value
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= 3'b111;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with host byte interface, no clock stretching
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR      = 7'h50,
    parameter int                CLK_PER_SCL_MIN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    i2c_slave_if.slave host
);

    if (CLK_PER_SCL_MIN < 8) begin : g_timing_check
        $error("i2c_slave: CLK_PER_SCL_MIN below 8 leaves no margin for the synchronizers");
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_cond, stop_cond;
    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;

    i2c_state_t state_q, state_nxt;
    logic [2:0] cnt_q, cnt_nxt;
    logic [7:0] shift_q, shift_nxt, shift_in;
    logic [7:0] tx_shift_q, tx_shift_nxt;
    logic [7:0] rx_data_q, rx_data_nxt;
    // flag_q: byte complete (ADDR/WRITE) or master ACK seen (READ_ACK)
    logic       flag_q, flag_nxt;
    logic       nack_q, nack_nxt;
    logic       sda_low_q, sda_low_nxt;
    logic       rw_q, rw_nxt;
    logic       busy_q, busy_nxt;
    logic       rx_valid_q, rx_valid_nxt;
    logic       tx_next_q, tx_next_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            flag_q     <= 1'b0;
            nack_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_next_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            shift_q    <= shift_nxt;
            tx_shift_q <= tx_shift_nxt;
            rx_data_q  <= rx_data_nxt;
            flag_q     <= flag_nxt;
            nack_q     <= nack_nxt;
            sda_low_q  <= sda_low_nxt;
            rw_q       <= rw_nxt;
            busy_q     <= busy_nxt;
            rx_valid_q <= rx_valid_nxt;
            tx_next_q  <= tx_next_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        shift_nxt    = shift_q;
        tx_shift_nxt = tx_shift_q;
        rx_data_nxt  = rx_data_q;
        flag_nxt     = flag_q;
        nack_nxt     = nack_q;
        sda_low_nxt  = sda_low_q;
        rw_nxt       = rw_q;
        busy_nxt     = busy_q;
        rx_valid_nxt = 1'b0;
        tx_next_nxt  = 1'b0;
        shift_in     = {shift_q[6:0], sda_lvl};

        // bus conditions outrank any data edge seen in the same cycle
        if (start_cond) begin
            state_nxt   = ST_ADDR;
            cnt_nxt     = 3'd7;
            shift_nxt   = '0;
            flag_nxt    = 1'b0;
            nack_nxt    = 1'b0;
            sda_low_nxt = 1'b0;
        end else if (stop_cond) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = 3'd7;
            flag_nxt    = 1'b0;
            nack_nxt    = 1'b0;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_low_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                end
                ST_ADDR, ST_WRITE: begin
                    if (scl_rise) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            flag_nxt = 1'b1;
                            if (state_q == ST_WRITE) begin
                                rx_data_nxt  = shift_in;
                                rx_valid_nxt = 1'b1;
                            end
                        end
                    end else if (scl_fall && flag_q) begin
                        flag_nxt = 1'b0;
                        if (state_q == ST_ADDR) begin
                            if (addr_match(shift_q, SLAVE_ADDR)) begin
                                state_nxt   = ST_ADDR_ACK;
                                sda_low_nxt = 1'b1;
                                rw_nxt      = shift_q[0];
                                busy_nxt    = 1'b1;
                            end else begin
                                state_nxt   = ST_IGNORE;
                                sda_low_nxt = 1'b0;
                            end
                        end else begin
                            // a NACKed byte still spends one ACK clock in WRITE_ACK
                            state_nxt   = ST_WRITE_ACK;
                            sda_low_nxt = host.ack_en;
                            nack_nxt    = ~host.ack_en;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = 3'd7;
                        if (rw_q) begin
                            tx_shift_nxt = host.tx_data;
                            tx_next_nxt  = 1'b1;
                            sda_low_nxt  = ~host.tx_data[7];
                            state_nxt    = ST_READ;
                        end else begin
                            sda_low_nxt = 1'b0;
                            state_nxt   = ST_WRITE;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                        cnt_nxt     = 3'd7;
                        nack_nxt    = 1'b0;
                        state_nxt   = nack_q ? ST_IGNORE : ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_low_nxt = 1'b0;
                            cnt_nxt     = 3'd7;
                            state_nxt   = ST_READ_ACK;
                        end else begin
                            cnt_nxt      = cnt_q - 3'd1;
                            tx_shift_nxt = {tx_shift_q[6:0], 1'b0};
                            sda_low_nxt  = ~tx_shift_q[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK) begin
                            flag_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end else if (scl_fall && flag_q) begin
                        flag_nxt     = 1'b0;
                        tx_shift_nxt = host.tx_data;
                        tx_next_nxt  = 1'b1;
                        sda_low_nxt  = ~host.tx_data[7];
                        cnt_nxt      = 3'd7;
                        state_nxt    = ST_READ;
                    end
                end
                ST_IGNORE: begin
                    sda_low_nxt = 1'b0;
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    sda_low_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda = sda_low_q ? 1'b0 : 1'bz;

    assign host.tx_next  = tx_next_q;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.rw       = rw_q;
    assign host.busy     = busy_q;
    assign host.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int         Q    = 5;
    localparam logic [6:0] ADDR = 7'h50;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_if hif ();

    i2c_slave #(.SLAVE_ADDR(ADDR), .CLK_PER_SCL_MIN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .host  (hif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] tx_src [8] = '{8'h96, 8'h5A, 8'hC3, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    int tx_idx = 0;
    assign hif.tx_data = tx_src[tx_idx % 8];

    typedef enum {PH_IDLE, PH_ADDR, PH_WRITE, PH_READ, PH_IGN} phase_t;
    phase_t     m_phase       = PH_IDLE;
    bit         exp_busy      = 1'b0;
    bit         exp_rw        = 1'b0;
    bit         exp_slave_low = 1'b0;
    int         exp_rx_cnt    = 0;
    int         exp_tx_cnt    = 0;
    int         m_rd_idx      = 0;
    logic [7:0] exp_rx_q [$];

    int rx_cnt      = 0;
    int tx_cnt      = 0;
    int hi_cnt      = 0;
    bit mon_en      = 1'b0;
    bit slave_drove = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pulse bookkeeping, host byte delivery and bus/status comparison
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (scl) hi_cnt++; else hi_cnt = 0;
        if (reset) begin
            if (!m_low && sda === 1'b0) slave_drove = 1'b1;
            if (hif.rx_valid) begin
                rx_cnt++;
                e = 8'hxx;
                if (exp_rx_q.size() > 0) e = exp_rx_q.pop_front();
                chk("rx_data_on_valid", hif.rx_data, e);
            end
            if (hif.tx_next) begin
                tx_cnt++;
                tx_idx++;
            end
            if (mon_en && scl && hi_cnt >= 4) begin
                chk("bus_sda", sda, !(m_low || exp_slave_low));
                chk("busy", hif.busy, exp_busy);
                chk("rw", hif.rw, exp_rw);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input bit b);
        m_low = !b;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output bit b);
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        b = (sda === 1'b1);
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
        m_phase = PH_ADDR;
    endtask

    task automatic bus_stop();
        mon_en = 1'b0;
        m_low  = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b0;
        tick(2 * Q);
        exp_busy = 1'b0;
        m_phase  = PH_IDLE;
        mon_en   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_ack, set_busy, new_rw, got;
        exp_ack  = 1'b0;
        set_busy = 1'b0;
        new_rw   = exp_rw;
        case (m_phase)
            PH_ADDR: begin
                if (b[7:1] == ADDR) begin
                    exp_ack  = 1'b1;
                    set_busy = 1'b1;
                    new_rw   = b[0];
                    if (b[0]) begin
                        m_phase = PH_READ;
                        exp_tx_cnt++;
                    end else begin
                        m_phase = PH_WRITE;
                    end
                end else begin
                    m_phase = PH_IGN;
                end
            end
            PH_WRITE: begin
                exp_rx_q.push_back(b);
                exp_rx_cnt++;
                exp_ack = hif.ack_en;
                if (!hif.ack_en) m_phase = PH_IGN;
            end
            default: ;
        endcase
        exp_slave_low = 1'b0;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        if (set_busy) exp_busy = 1'b1;
        exp_rw        = new_rw;
        exp_slave_low = exp_ack;
        read_bit(got);
        chk("ack_bit", got, !exp_ack);
        exp_slave_low = 1'b0;
    endtask

    task automatic recv_byte(input bit mack, output logic [7:0] got);
        logic [7:0] e;
        bit b;
        e = tx_src[m_rd_idx % 8];
        m_rd_idx++;
        for (int i = 7; i >= 0; i--) begin
            exp_slave_low = !e[i];
            read_bit(b);
            got[i] = b;
        end
        exp_slave_low = 1'b0;
        chk("read_byte_model", got, e);
        if (mack) exp_tx_cnt++; else m_phase = PH_IGN;
        write_bit(!mack);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] g;
        bit b;
        hif.ack_en = 1'b1;
        tick(4);
        chk("rst_state", hif.state, 4'd0);
        chk("rst_busy", hif.busy, 1'b0);
        chk("rst_rw", hif.rw, 1'b0);
        chk("rst_rx_data", hif.rx_data, 8'h00);
        chk("rst_rx_valid", hif.rx_valid, 1'b0);
        chk("rst_tx_next", hif.tx_next, 1'b0);
        chk("rst_sda", sda, 1'b1);
        reset = 1'b1;
        tick(4);
        mon_en = 1'b1;

        // write 0xA0, 0x3C
        bus_start();
        send_byte(8'hA0);
        send_byte(8'h3C);
        chk("wr_rx_data", hif.rx_data, 8'h3C);
        chk("wr_rw", hif.rw, 1'b0);
        chk("wr_rx_pulses", rx_cnt, 1);
        bus_stop();
        chk("wr_idle_state", hif.state, 4'd0);

        // read 0xA1, master ACK then NACK
        bus_start();
        send_byte(8'hA1);
        recv_byte(1'b1, g);
        chk("rd_byte0", g, 8'h96);
        recv_byte(1'b0, g);
        chk("rd_byte1", g, 8'h5A);
        chk("rd_ignore_state", hif.state, 4'd7);
        chk("rd_tx_pulses", tx_cnt, 2);
        bus_stop();
        chk("rd_idle_state", hif.state, 4'd0);

        // address mismatch
        slave_drove = 1'b0;
        bus_start();
        send_byte(8'h42);
        send_byte(8'hA0);
        chk("miss_state", hif.state, 4'd7);
        chk("miss_busy", hif.busy, 1'b0);
        chk("miss_no_drive", slave_drove, 1'b0);
        bus_stop();
        chk("miss_idle_state", hif.state, 4'd0);

        // write then repeated START into a read
        bus_start();
        send_byte(8'hA0);
        send_byte(8'h11);
        chk("rs_rw_write", hif.rw, 1'b0);
        chk("rs_rx_data", hif.rx_data, 8'h11);
        bus_start();
        send_byte(8'hA1);
        chk("rs_rw_read", hif.rw, 1'b1);
        recv_byte(1'b0, g);
        chk("rs_rd_byte", g, 8'hC3);
        bus_stop();

        // data NACK with ack_en low, following byte ignored
        hif.ack_en = 1'b0;
        bus_start();
        send_byte(8'hA0);
        send_byte(8'h5E);
        send_byte(8'h99);
        chk("nack_rx_data", hif.rx_data, 8'h5E);
        chk("nack_state", hif.state, 4'd7);
        bus_stop();
        hif.ack_en = 1'b1;

        // reset during the low phase of read bit 3 (tx byte 0xF0)
        bus_start();
        send_byte(8'hA1);
        exp_slave_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_bit(b);
            chk("rst_rd_hi_bits", b, 1'b1);
        end
        m_rd_idx++;
        chk("rst_rd_bit3_low", sda, 1'b0);
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_sda", sda, 1'b1);
        chk("rst_mid_state", hif.state, 4'd0);
        chk("rst_mid_busy", hif.busy, 1'b0);
        tick(3);
        reset    = 1'b1;
        exp_busy = 1'b0;
        exp_rw   = 1'b0;
        m_phase  = PH_IDLE;
        slave_drove = 1'b0;
        mon_en   = 1'b1;
        write_bit(1'b1);
        write_bit(1'b0);
        chk("post_rst_state", hif.state, 4'd0);
        chk("post_rst_no_drive", slave_drove, 1'b0);
        bus_start();
        send_byte(8'hA0);
        send_byte(8'h77);
        chk("post_rst_rx_data", hif.rx_data, 8'h77);
        bus_stop();

        chk("total_rx_pulses", rx_cnt, exp_rx_cnt);
        chk("total_tx_pulses", tx_cnt, exp_tx_cnt);
        chk("total_rx_pulses_lit", rx_cnt, 4);
        chk("total_tx_pulses_lit", tx_cnt, 4);
        chk("rx_queue_drained", exp_rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
